// File: rtl/polar_channel_scheduler.sv
// Shares one iterative rect-to-polar engine across CHANELS bins, one channel at a time.
// Optional engine watchdog enabled by defining SCHED_TIMEOUT_EN.
module polar_channel_scheduler #(
  parameter int CHANELS  = 2,
  parameter int WIDTH_XY = 32,
  parameter int WIDTH_PH = 32,
  parameter int TIMEOUT  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_vld,
  input  logic [CHANELS*WIDTH_XY-1:0]  i_x,
  input  logic [CHANELS*WIDTH_XY-1:0]  i_y,
  output logic                         i_rdy,
  output logic                         c_start,
  output logic [WIDTH_XY-1:0]          c_x,
  output logic [WIDTH_XY-1:0]          c_y,
  input  logic                         c_vld,
  input  logic [WIDTH_XY-1:0]          c_mag,
  input  logic [WIDTH_PH-1:0]          c_phase,
  output logic [CHANELS*WIDTH_XY-1:0]  o_mag,
  output logic [CHANELS*WIDTH_PH-1:0]  o_phase,
  output logic [WIDTH_PH-1:0]          o_dph,
  output logic                         o_vld,
  output logic                         o_ovf,
  output logic                         o_err,
  output logic [1:0]                   dbg_state,
  output logic [$clog2(TIMEOUT+1)-1:0] dbg_wait_cnt
);

  // Handshake: the frame is taken when i_vld is high while i_rdy is high (IDLE only);
  // c_start is a one-cycle request, c_x/c_y stay stable until c_vld is seen in WAIT.

  localparam int IDX_W = (CHANELS > 1) ? $clog2(CHANELS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANELS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t                        state, state_nxt;
  logic [IDX_W-1:0]              idx;
  logic [CHANELS*WIDTH_XY-1:0]   lat_x, lat_y;
  logic [CHANELS*WIDTH_XY-1:0]   res_mag, res_mag_nxt;
  logic [CHANELS*WIDTH_PH-1:0]   res_ph, res_ph_nxt;
  logic [WIDTH_PH-1:0]           dph_nxt;
  logic [CNT_W-1:0]              wait_cnt;
  logic                          tmo_hit, capture;
  logic [WIDTH_XY-1:0]           cap_mag;
  logic [WIDTH_PH-1:0]           cap_ph;

`ifdef SCHED_TIMEOUT_EN
  assign tmo_hit = (state == WAIT) && !c_vld && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign capture = (state == WAIT) && (c_vld || tmo_hit);
  assign cap_mag = tmo_hit ? '0 : c_mag;
  assign cap_ph  = tmo_hit ? '0 : c_phase;

  assign c_x = lat_x[32'(idx)*WIDTH_XY +: WIDTH_XY];
  assign c_y = lat_y[32'(idx)*WIDTH_XY +: WIDTH_XY];

  assign dbg_state    = state;
  assign dbg_wait_cnt = wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (capture) state_nxt = (idx == LAST_IDX) ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    i_rdy   = (state == IDLE);
    c_start = (state == ISSUE);
    o_vld   = (state == DONE);
  end

  // Result set as it will look after this cycle's capture, so DONE can publish it directly.
  always_comb begin
    res_mag_nxt = res_mag;
    res_ph_nxt  = res_ph;
    if (capture) begin
      res_mag_nxt[32'(idx)*WIDTH_XY +: WIDTH_XY] = cap_mag;
      res_ph_nxt[32'(idx)*WIDTH_PH +: WIDTH_PH]  = cap_ph;
    end
  end

  generate
    if (CHANELS == 1) begin : g_one
      assign dph_nxt = res_ph_nxt[WIDTH_PH-1:0];
    end else begin : g_multi
      assign dph_nxt = res_ph_nxt[WIDTH_PH-1:0] - res_ph_nxt[2*WIDTH_PH-1:WIDTH_PH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      lat_x    <= '0;
      lat_y    <= '0;
      res_mag  <= '0;
      res_ph   <= '0;
      o_mag    <= '0;
      o_phase  <= '0;
      o_dph    <= '0;
      o_ovf    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (i_vld && (state == IDLE)) begin
        lat_x <= i_x;
        lat_y <= i_y;
        idx   <= '0;
      end
      if (i_vld && (state != IDLE)) o_ovf <= 1'b1;

      if (state == ISSUE) wait_cnt <= '0;
      else if ((state == WAIT) && (wait_cnt != CNT_W'(TIMEOUT))) wait_cnt <= wait_cnt + CNT_W'(1);

      if (capture) begin
        res_mag <= res_mag_nxt;
        res_ph  <= res_ph_nxt;
        if (idx == LAST_IDX) begin
          o_mag   <= res_mag_nxt;
          o_phase <= res_ph_nxt;
          o_dph   <= dph_nxt;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

`ifdef SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst)          o_err <= 1'b0;
    else if (tmo_hit) o_err <= 1'b1;
  end
`else
  assign o_err = 1'b0;
`endif

endmodule
